// File: rtl/ac_pkg.sv
// Shared definitions for the air-conditioning control slice.
// Holds the sequencer state encoding and the default dwell timings so the
// AC decision block, the sequencer and the benches agree on them.
package ac_pkg;

   // state encoding, also visible on the sequencer's state output
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_HEAT = 2'b01;
   localparam logic [1:0] ST_COOL = 2'b10;
   localparam logic [1:0] ST_REST = 2'b11;

   localparam int MIN_ON_DEF  = 8;
   localparam int MIN_OFF_DEF = 4;
   localparam int CNT_W_DEF   = 8;

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter for the HVAC sequencer.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   clr       - clear the count to zero (takes priority over inc)
//   inc       - increment by one; the count saturates at all-ones
//   limit     - runtime terminal value to compare against
//   done      - registered flag: the count now held is >= limit
module dwell_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   input  logic [CNT_W-1:0] limit,
   output logic             done
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   always_comb begin
      cnt_nxt = cnt;
      if (clr)
         cnt_nxt = '0;
      else if (inc && (cnt != {CNT_W{1'b1}}))
         cnt_nxt = cnt + 1'b1;
   end

   // The compare uses the value being loaded, so done lines up with the
   // count it describes rather than lagging it by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         done <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         done <= (cnt_nxt >= limit);
      end
   end

endmodule

// File: rtl/hvac_sequencer.sv
// Compressor-protection sequencer between the AC decision block and the
// heater/cooler actuators. Enforces a minimum on-time per run and a fixed
// rest interval after every run; contradictory requests are flagged.
// Ports:
//   clk, rst           - clock and synchronous active-high reset
//   enable             - master run permit
//   heat_req, cool_req - raw requests from the AC decision block
//   heat_on, cool_on   - actuator enables (decoded from state)
//   state              - IDLE=00, HEAT=01, COOL=10, REST=11
//   conflict           - registered heat_req & cool_req
//
// state | meaning
// IDLE  | no actuator on, waiting for a single clean request
// HEAT  | heater on, min-on window then held while heat_req persists
// COOL  | cooler on, min-on window then held while cool_req persists
// REST  | both off for exactly MIN_OFF cycles, requests ignored
module hvac_sequencer
   import ac_pkg::*;
#(
   parameter int MIN_ON  = MIN_ON_DEF,
   parameter int MIN_OFF = MIN_OFF_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       heat_req,
   input  logic       cool_req,
   output logic       heat_on,
   output logic       cool_on,
   output logic [1:0] state,
   output logic       conflict
);

   logic [1:0]       state_nxt;
   logic             done;
   logic             clr;
   logic             inc;
   logic [CNT_W-1:0] limit;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (enable && heat_req && !cool_req)
               state_nxt = ST_HEAT;
            else if (enable && cool_req && !heat_req)
               state_nxt = ST_COOL;
         end
         ST_HEAT: begin
            if (done && (!heat_req || cool_req || !enable))
               state_nxt = ST_REST;
         end
         ST_COOL: begin
            if (done && (!cool_req || heat_req || !enable))
               state_nxt = ST_REST;
         end
         default: begin
            if (done)
               state_nxt = ST_IDLE;
         end
      endcase
   end

   // The limit follows the state being entered, so the registered compare
   // already refers to the right window on the first cycle of a new state.
   always_comb begin
      clr   = (state_nxt != state);
      inc   = (state != ST_IDLE) && !done;
      limit = (state_nxt == ST_REST) ? CNT_W'(MIN_OFF - 1) : CNT_W'(MIN_ON - 1);
   end

   dwell_timer #(
      .CNT_W (CNT_W)
   ) u_dwell (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .inc   (inc),
      .limit (limit),
      .done  (done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         conflict <= 1'b0;
      end else begin
         state    <= state_nxt;
         conflict <= heat_req & cool_req;
      end
   end

   assign heat_on = (state == ST_HEAT);
   assign cool_on = (state == ST_COOL);

endmodule

// File: doc/hvac_sequencer.md
# hvac_sequencer

Compressor-protection sequencer between the air-conditioning decision block and the heater/cooler actuators. Takes the raw heating/cooling requests and turns them into actuator enables that never chatter: each actuator stays on for a minimum dwell, and the plant rests for a fixed interval before any restart or heat/cool changeover. Contradictory requests are rejected and flagged.

## Interface

- MIN_ON, default 8: minimum cycles an actuator enable stays high once asserted; legal range 1 to 2**CNT_W-1.
- MIN_OFF, default 4: exact cycles of rest after any actuator turns off; legal range 1 to 2**CNT_W-1.
- CNT_W, default 8: dwell counter width.

- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  master run permit.
- heat_req  in  1  heating request from the AC decision block.
- cool_req  in  1  cooling request from the AC decision block.
- heat_on  out  1  heater enable.
- cool_on  out  1  cooler enable.
- state  out  2  current state: IDLE=00, HEAT=01, COOL=10, REST=11.
- conflict  out  1  registered flag; high the cycle after heat_req and cool_req were both sampled high.

## Operation

- One clock, synchronous active-high reset. All outputs are registered or decoded from the state register; there is no combinational path from inputs to outputs.
- Reset values: state=IDLE, counter=0, heat_on=0, cool_on=0, conflict=0. rst overrides every other condition, including min-on, and takes effect at the next edge.
- heat_on = (state==HEAT), cool_on = (state==COOL). They are never both high.
- The dwell counter clears on every state transition.
- IDLE:
  - enable & heat_req & !cool_req -> HEAT.
  - enable & cool_req & !heat_req -> COOL.
  - Otherwise, including both requests high, stay in IDLE.
- HEAT:
  - While cnt < MIN_ON-1: increment and stay.
  - Otherwise, if release (!heat_req | cool_req | !enable): go to REST.
  - Otherwise stay, with the counter saturated.
  - COOL behaves the same with heat and cool swapped.
- REST:
  - Both enables are low and all requests are ignored.
  - While cnt < MIN_OFF-1: increment.
  - Otherwise -> IDLE.
- A changeover always passes HEAT -> REST -> IDLE -> COOL. There is no direct HEAT<->COOL arc.
- conflict is sampled every cycle, in every state, as heat_req & cool_req. It is 0 during and immediately after reset.

## Timing

- Start latency: a request sampled at edge N in IDLE gives an enable high from edge N onward, visible in cycle N+1.
- Minimum on-time: an enable stays high for at least MIN_ON cycles, and exactly MIN_ON cycles if the release condition already holds at entry.
- After a release seen once cnt has saturated, the enable drops at the next edge.
- REST lasts exactly MIN_OFF cycles. The state is then IDLE for at least 1 cycle.
- The minimum gap from one enable falling to any enable rising is MIN_OFF+1 cycles.
- enable going low during the min-on window does not cut the window short; the exit happens at the first edge after the window.
- Requests toggling during REST have no effect. Only levels sampled in IDLE start a run.

## Structure

- Shared package ac_pkg holds:
  - the state encoding constants (IDLE, HEAT, COOL, REST);
  - default MIN_ON/MIN_OFF/CNT_W constants, so that the AC block, the sequencer and the benches agree.
- One sub-module, dwell_timer: a CNT_W-bit counter with clear, increment-enable, saturation, and a registered reached-limit compare against a runtime limit input. It is instantiated once, with the limit muxed between MIN_ON-1 and MIN_OFF-1 according to state.
- The top level holds the FSM, output decode and conflict register.

## Test plan

All scenarios use MIN_ON=8 and MIN_OFF=4.

- Reset then idle: rst high for 2 cycles with requests high -> all outputs 0 and state=00 while rst is high and for 1 cycle after it releases, then normal start.
- Short heat pulse: enable=1, heat_req high for 1 cycle -> heat_on high for exactly 8 cycles, REST for exactly 4 cycles, then IDLE; cool_on stays 0 throughout.
- Long heat: heat_req held high for 20 cycles -> heat_on high for 20 cycles, falls at the edge after heat_req drops, then 4 cycles of REST.
- Changeover: heat run active, then heat_req=0 and cool_req=1 at cycle 10 -> heat_on falls, 4 REST cycles, 1 IDLE cycle, then cool_on rises; the two enables never overlap.
- Conflict: heat_req=cool_req=1 in IDLE for 3 cycles -> state stays 00 and conflict is high for 3 cycles, delayed by 1 cycle.
- Mid-run disruptions:
  - enable dropped at cycle 3 of a cool run -> cool_on still lasts 8 cycles.
  - rst asserted at cycle 5 of a heat run -> heat_on is 0 at the next edge and state=00, with no REST.
